// File: rtl/pkt_parse_arbiter_if.sv
// pkt_parse_arbiter_if: requester and output handshake bundle
// for the packet parse arbiter.
interface pkt_parse_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CTLW    = 33,
    parameter int PAYLOAD = 32,
    parameter int SRCW    = 2
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ*CTLW-1:0]    req_ctl;
    logic [NUM_REQ*PAYLOAD-1:0] req_payload;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTLW-1:0]            out_ctl;
    logic [PAYLOAD-1:0]         out_payload;
    logic                       out_last;
    logic [SRCW-1:0]            out_src;

    modport master (
        output req_valid,
        output req_last,
        output req_ctl,
        output req_payload,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_ctl,
        input  out_payload,
        input  out_last,
        input  out_src
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_ctl,
        input  req_payload,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_ctl,
        output out_payload,
        output out_last,
        output out_src
    );
endinterface

// File: rtl/pkt_parse_arbiter.sv
// pkt_parse_arbiter: round-robin packet arbiter feeding the payload
// parse stage; drops zero-control packets and truncates long ones.
module pkt_parse_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PARITY    = 1,
    parameter int FLAGS     = 12,
    parameter int ADDR      = 20,
    parameter int PAYLOAD   = 32,
    parameter int MAX_BEATS = 16,
    localparam int CTLW = PARITY + FLAGS + ADDR,
    localparam int SRCW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW  = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pkt_parse_arbiter_if.slave bus,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        trunc_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        FWD,
        DROP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SRCW-1:0]    grant;
    logic [SRCW-1:0]    grant_inc;
    logic [SRCW-1:0]    rr_ptr;
    logic [SRCW-1:0]    pick;
    logic               pick_ok;
    logic [SRCW-1:0]    scan [NUM_REQ];
    logic [BCW-1:0]     bcnt;
    logic [BCW-1:0]     bcnt_inc;
    logic [CTLW-1:0]    ctl_a [NUM_REQ];
    logic [PAYLOAD-1:0] pay_a [NUM_REQ];
    logic [CTLW-1:0]    g_ctl;
    logic [PAYLOAD-1:0] g_pay;
    logic               g_valid;
    logic               g_last;
    logic               g_zero;
    logic               g_rdy;
    logic               xfer;
    logic               load_ok;
    logic               cap_hit;
    logic               leave;
    logic               ld;
    logic               ld_last;
    logic               drop_hit;
    logic               trunc_hit;
    logic [NUM_REQ-1:0] rdy;

    // Unpack the per-requester control and payload lanes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ctl_a[i] = bus.req_ctl[i*CTLW +: CTLW];
            pay_a[i] = bus.req_payload[i*PAYLOAD +: PAYLOAD];
        end
    end

    // Requester indices in circular order starting at rr_ptr.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            scan[i] = SRCW'((int'(rr_ptr) + i) % NUM_REQ);
        end
    end

    // First valid requester in scan order; lowest offset wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[scan[i]]) begin
                pick    = scan[i];
                pick_ok = 1'b1;
            end
        end
    end

    assign g_valid   = bus.req_valid[grant];
    assign g_last    = bus.req_last[grant];
    assign g_ctl     = ctl_a[grant];
    assign g_pay     = pay_a[grant];
    assign g_zero    = (g_ctl == '0);
    assign load_ok   = !bus.out_valid || bus.out_ready;
    assign xfer      = g_valid && g_rdy;
    assign bcnt_inc  = bcnt + 1'b1;
    assign cap_hit   = (bcnt_inc == BCW'(MAX_BEATS));
    assign leave     = (state != IDLE) && (state_nx == IDLE);
    assign grant_inc = (grant == SRCW'(NUM_REQ - 1)) ? '0
                                                     : grant + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: packet boundaries, drops and truncation.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (pick_ok) state_nx = ARB;
            end
            ARB: begin
                if (xfer) begin
                    if (g_last)      state_nx = IDLE;
                    else if (g_zero) state_nx = DROP;
                    else             state_nx = FWD;
                end
            end
            FWD: begin
                if (xfer) begin
                    if (g_last)       state_nx = IDLE;
                    else if (cap_hit) state_nx = DROP;
                end
            end
            DROP: begin
                if (xfer && g_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: ready for the granted lane and beat load strobes.
    always_comb begin
        g_rdy     = 1'b0;
        ld        = 1'b0;
        ld_last   = 1'b0;
        drop_hit  = 1'b0;
        trunc_hit = 1'b0;
        unique case (1'b1)
            (state == ARB): begin
                g_rdy = load_ok;
                if (g_valid && load_ok) begin
                    drop_hit = g_zero;
                    ld       = !g_zero;
                    ld_last  = g_last;
                end
            end
            (state == FWD): begin
                g_rdy = load_ok;
                if (g_valid && load_ok) begin
                    ld        = 1'b1;
                    ld_last   = g_last || cap_hit;
                    trunc_hit = !g_last && cap_hit;
                end
            end
            (state == DROP): begin
                g_rdy = 1'b1;
            end
            default: begin
                g_rdy = 1'b0;
            end
        endcase
    end

    // One-hot ready toward the granted requester only.
    always_comb begin
        rdy        = '0;
        rdy[grant] = g_rdy;
    end

    assign bus.req_ready = rdy;

    // Grant latch, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= '0;
            bcnt   <= '0;
        end else begin
            if (state == IDLE && pick_ok) grant <= pick;
            if (leave) rr_ptr <= grant_inc;
            if (ld) begin
                bcnt <= (state == ARB) ? BCW'(1) : bcnt_inc;
            end
        end
    end

    // Registered output stage; holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_ctl     <= '0;
            bus.out_payload <= '0;
            bus.out_last    <= 1'b0;
            bus.out_src     <= '0;
        end else if (ld) begin
            bus.out_valid   <= 1'b1;
            bus.out_ctl     <= g_ctl;
            bus.out_payload <= g_pay;
            bus.out_last    <= ld_last;
            bus.out_src     <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

    // Saturating drop and truncation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (drop_hit && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (trunc_hit && trunc_cnt != 16'hFFFF) begin
                trunc_cnt <= trunc_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_parse_arbiter.sv
// tb_pkt_parse_arbiter: random and directed packet traffic checked
// against a packet-level round-robin reference model.
`timescale 1ns/1ps
module tb_pkt_parse_arbiter;

    localparam int NR     = 4;
    localparam int PARITY = 1;
    localparam int FLAGS  = 12;
    localparam int ADDR   = 20;
    localparam int PW     = 32;
    localparam int MAXB   = 16;
    localparam int CW     = PARITY + FLAGS + ADDR;
    localparam int SW     = 2;
    localparam int MAXP   = 8;

    typedef struct {
        logic [CW-1:0] ctl;
        int            len;
        logic [PW-1:0] pbase;
    } pkt_t;

    typedef struct {
        logic [CW-1:0] ctl;
        logic [PW-1:0] pay;
        logic          last;
        int            src;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] drop_cnt;
    logic [15:0] trunc_cnt;

    pkt_parse_arbiter_if #(
        .NUM_REQ(NR), .CTLW(CW), .PAYLOAD(PW), .SRCW(SW)
    ) bus ();

    pkt_parse_arbiter #(
        .NUM_REQ(NR), .PARITY(PARITY), .FLAGS(FLAGS),
        .ADDR(ADDR), .PAYLOAD(PW), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .drop_cnt(drop_cnt),
        .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    pkt_t          pk [NR][MAXP];
    int            pcnt [NR];
    int            pidx [NR];
    int            bidx [NR];
    beat_t         expq [$];
    int            m_rr, exp_drop, exp_trunc;
    int            ntests, nfail;
    int            nout, ncyc, orm;
    bit            gaps, lat_on, abort;
    int            first_acc, first_ov;
    logic [NR-1:0] rx;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] bctl(pkt_t p, int b);
        return (b == 0) ? p.ctl : (p.ctl ^ CW'(b * 32'h9E37));
    endfunction

    function automatic logic [PW-1:0] bpay(pkt_t p, int b);
        return PW'(p.pbase * PW'(b + 1));
    endfunction

    task automatic clear_pk();
        for (int r = 0; r < NR; r++) begin
            pcnt[r] = 0;
            pidx[r] = 0;
            bidx[r] = 0;
        end
    endtask

    task automatic add_pkt(input int r, input logic [CW-1:0] c,
                           input int len, input logic [PW-1:0] pb);
        pk[r][pcnt[r]] = '{ctl: c, len: len, pbase: pb};
        pcnt[r]++;
    endtask

    // Packet-level reference: rotate over requesters with work left.
    task automatic model();
        int    k [NR];
        int    s, n, left;
        pkt_t  p;
        beat_t e;
        left = 0;
        for (int r = 0; r < NR; r++) begin
            k[r] = 0;
            left += pcnt[r];
        end
        while (left > 0) begin
            s = -1;
            for (int i = 0; i < NR; i++) begin
                if (s < 0 && k[(m_rr + i) % NR] < pcnt[(m_rr + i) % NR])
                    s = (m_rr + i) % NR;
            end
            p = pk[s][k[s]];
            k[s]++;
            left--;
            if (p.ctl == '0) begin
                exp_drop++;
            end else begin
                n = (p.len > MAXB) ? MAXB : p.len;
                if (p.len > MAXB) exp_trunc++;
                for (int b = 0; b < n; b++) begin
                    e.ctl  = bctl(p, b);
                    e.pay  = bpay(p, b);
                    e.last = (b == n - 1);
                    e.src  = s;
                    expq.push_back(e);
                end
            end
            m_rr = (s + 1) % NR;
        end
    endtask

    task automatic drive();
        logic [NR-1:0]    v, l;
        logic [NR*CW-1:0] c;
        logic [NR*PW-1:0] d;
        pkt_t             p;
        int               b;
        v = '0;
        l = '0;
        c = '0;
        d = '0;
        for (int r = 0; r < NR; r++) begin
            if (pidx[r] < pcnt[r]) begin
                p = pk[r][pidx[r]];
                b = bidx[r];
                if (b == 0 || !gaps || $urandom_range(3) != 0) begin
                    v[r]           = 1'b1;
                    l[r]           = (b == p.len - 1);
                    c[r*CW +: CW]  = bctl(p, b);
                    d[r*PW +: PW]  = bpay(p, b);
                end
            end
        end
        bus.req_valid   = v;
        bus.req_last    = l;
        bus.req_ctl     = c;
        bus.req_payload = d;
        case (orm)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            2:       bus.out_ready = ($urandom_range(3) != 0);
            3:       bus.out_ready = (ncyc % 4 == 0) || (ncyc % 4 == 3);
            default: bus.out_ready = (nout < 1);
        endcase
    endtask

    task automatic tick();
        beat_t e;
        @(negedge clk);
        ncyc++;
        rx = bus.req_valid & bus.req_ready;
        if (lat_on) begin
            if (first_acc < 0 && rx != '0) first_acc = ncyc;
            if (first_ov < 0 && bus.out_valid) first_ov = ncyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            nout++;
            if (expq.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                check("out_src", 64'(bus.out_src), 64'(e.src));
                check("out_ctl", 64'(bus.out_ctl), 64'(e.ctl));
                check("out_payload", 64'(bus.out_payload), 64'(e.pay));
                check("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
        if (orm == 4 && bus.out_valid && !bus.out_ready && nout == 1)
            abort = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (rx[r]) begin
                bidx[r]++;
                if (bidx[r] == pk[r][pidx[r]].len) begin
                    pidx[r]++;
                    bidx[r] = 0;
                end
            end
        end
        drive();
    endtask

    task automatic run(input int mode, input bit g, input bit lat);
        int  budget, cyc;
        bit  done;
        orm       = mode;
        gaps      = g;
        lat_on    = lat;
        first_acc = -1;
        first_ov  = -1;
        nout      = 0;
        abort     = 1'b0;
        budget    = 100;
        for (int r = 0; r < NR; r++) begin
            pidx[r] = 0;
            bidx[r] = 0;
            for (int j = 0; j < pcnt[r]; j++)
                budget += 8 * pk[r][j].len + 4;
        end
        model();
        drive();
        cyc  = 0;
        done = 1'b0;
        while (!done && !abort && cyc < budget) begin
            tick();
            cyc++;
            done = (expq.size() == 0);
            for (int r = 0; r < NR; r++)
                if (pidx[r] != pcnt[r]) done = 1'b0;
        end
        if (!abort) begin
            check("timeout", 64'(done), 64'd1);
            repeat (4) tick();
            check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            check("trunc_cnt", 64'(trunc_cnt), 64'(exp_trunc));
            if (lat) check("latency", 64'(first_ov - first_acc), 64'd1);
        end
        expq.delete();
    endtask

    task automatic rand_load();
        int            n, len;
        logic [CW-1:0] c;
        clear_pk();
        for (int r = 0; r < NR; r++) begin
            n = $urandom_range(3);
            for (int j = 0; j < n; j++) begin
                c   = CW'({$urandom(), $urandom()});
                if ($urandom_range(5) == 0) c = '0;
                len = $urandom_range(20, 1);
                add_pkt(r, c, len, PW'($urandom()));
            end
        end
    endtask

    initial begin
        ntests    = 0;
        nfail     = 0;
        m_rr      = 0;
        exp_drop  = 0;
        exp_trunc = 0;
        ncyc      = 0;
        nout      = 0;
        orm       = 0;
        gaps      = 1'b0;
        lat_on    = 1'b0;
        abort     = 1'b0;
        rx        = '0;
        clear_pk();
        bus.req_valid   = '0;
        bus.req_last    = '0;
        bus.req_ctl     = '0;
        bus.req_payload = '0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_src", 64'(bus.out_src), 64'd0);
        check("rst_out_ctl", 64'(bus.out_ctl), 64'd0);
        check("rst_out_payload", 64'(bus.out_payload), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_trunc_cnt", 64'(trunc_cnt), 64'd0);
        @(posedge clk);
        #1;

        clear_pk();
        add_pkt(2, 33'h1ABC12345, 3, 32'h11);
        run(0, 1'b0, 1'b1);

        clear_pk();
        for (int r = 0; r < NR; r++)
            for (int j = 0; j < 3; j++)
                add_pkt(r, CW'(r * 16 + j + 1), 1, PW'(32'h1000 + r));
        run(0, 1'b0, 1'b0);

        clear_pk();
        add_pkt(1, '0, 4, 32'h40);
        add_pkt(1, CW'(33'h0_0000_0777), 2, 32'h50);
        run(1, 1'b0, 1'b0);

        clear_pk();
        add_pkt(0, CW'(33'h1_2345_6789), 20, 32'h3);
        run(2, 1'b1, 1'b0);

        clear_pk();
        add_pkt(3, CW'(33'h0_0F0F_0F0F), 4, 32'h100);
        run(3, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            rand_load();
            run(k % 4, 1'b1, 1'b0);
        end

        clear_pk();
        add_pkt(1, CW'(33'h0_0000_ABCD), 5, 32'h500);
        run(4, 1'b0, 1'b0);
        check("abort_reached", 64'(abort), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_pk();
        orm = 0;
        drive();
        @(negedge clk);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_drop_cnt", 64'(drop_cnt), 64'd0);
        check("abort_trunc_cnt", 64'(trunc_cnt), 64'd0);
        check("abort_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        m_rr      = 0;
        exp_drop  = 0;
        exp_trunc = 0;

        clear_pk();
        add_pkt(3, CW'(33'h0_0000_0033), 2, 32'h30);
        add_pkt(0, CW'(33'h0_0000_0011), 2, 32'h10);
        run(1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/pkt_parse_arbiter.md
Name: pkt_parse_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one packet payload parse datapath between NUM_REQ packet sources.
- Selects one requester per packet and forwards its beats (control word + payload) through a registered output stage with valid/ready handshake.
- Discards packets whose first-beat control word is all zero, and truncates packets longer than MAX_BEATS.
- Sits directly upstream of the payload parse register stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- PARITY, 1, parity field width of control word
- FLAGS, 12, flags field width of control word
- ADDR, 20, address field width of control word
- PAYLOAD, 32, payload width
- MAX_BEATS, 16, maximum beats forwarded per packet (>=2)
- Derived: CTLW = PARITY+FLAGS+ADDR; SRCW = max(1, clog2(NUM_REQ)); BCW = clog2(MAX_BEATS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_ctl  in  NUM_REQ*CTLW  packed control words; requester i at [i*CTLW +: CTLW]
- req_payload  in  NUM_REQ*PAYLOAD  packed payloads; requester i at [i*PAYLOAD +: PAYLOAD]
- req_ready  out  NUM_REQ  per-requester beat accept
- out_valid  out  1  forwarded beat valid
- out_ready  in  1  downstream accept
- out_ctl  out  CTLW  forwarded control word
- out_payload  out  PAYLOAD  forwarded payload
- out_last  out  1  last beat of forwarded packet
- out_src  out  SRCW  index of the requester owning the beat
- drop_cnt  out  16  count of packets dropped (zero control word); saturates at 0xFFFF
- trunc_cnt  out  16  count of packets truncated; saturates at 0xFFFF

Behaviour:
- Reset: state=IDLE; rr_ptr=0; out_valid=0; out_ctl/out_payload/out_last/out_src=0; req_ready=0; drop_cnt=0; trunc_cnt=0; beat counter=0.
- A beat transfers on requester i when req_valid[i] && req_ready[i]. Output transfers when out_valid && out_ready.
- Output stage is one register: load allowed when !out_valid || out_ready.
- State IDLE:
  - req_ready=0.
  - If any req_valid, grant the first requester at or after rr_ptr (circular search) and go to ARB.
  - Grant is registered, so a decision takes 1 cycle.
- State ARB (first beat of granted requester g):
  - req_ready[g] = load allowed; all other req_ready bits = 0.
  - On transfer, if req_ctl[g]==0: beat is not forwarded; drop_cnt++; next state is IDLE if req_last[g] is set, else DROP.
  - Otherwise: load beat into the output register; beat counter=1; next state is IDLE if req_last[g] is set, else FWD.
- State FWD:
  - Same ready rule as ARB; each transferred beat is loaded and the counter is incremented.
  - A beat with req_last[g] set loads with out_last=1; next state IDLE.
  - If the beat makes count == MAX_BEATS without req_last: load with out_last=1 forced; trunc_cnt++; next state DROP.
- State DROP:
  - req_ready[g]=1 unconditionally, independent of out_ready.
  - Beats are consumed and discarded until the req_last[g] beat transfers, then IDLE.
- rr_ptr updates to (g+1) mod NUM_REQ on leaving ARB, FWD or DROP for IDLE. Every requester is served within NUM_REQ packets.
- Latency: a first beat accepted in cycle t appears on out_* in cycle t+1. Minimum IDLE→ARB arbitration bubble is 1 cycle per packet.
- Full throughput inside a packet: back-to-back beats when out_ready is held high.
- Backpressure:
  - out_valid and out_* stay stable while out_valid && !out_ready.
  - out_valid deasserts after a transfer unless a new beat loads in the same cycle.
- Changes to req_valid of non-granted requesters never affect the current packet.
- A granted requester deasserting req_valid mid-packet simply stalls; the grant is held.
- Single-beat packet (first beat has last set) ends in ARB; out_last=1.
- Counters saturate at 0xFFFF and do not wrap.
- rst asserted mid-packet aborts the packet immediately. A beat already in the output register is discarded (out_valid=0 next cycle).

Test Plan:
- Reset, then requester 2 sends a 3-beat packet with ctl=0x1_ABC_12345 and payloads 0x11,0x22,0x33, out_ready=1 → out beats appear at t+1..t+3 with out_src=2 and matching payloads; out_last only on 0x33; rr_ptr becomes 3.
- All 4 requesters continuously send 1-beat packets → grant order 0,1,2,3,0,...; no requester is granted twice before the others.
- Requester 1 first beat ctl=0 in a 4-beat packet → nothing forwarded; req_ready[1] held high through the last beat; drop_cnt=1; the next packet from requester 1 is forwarded normally.
- MAX_BEATS=16, requester 0 sends 20 beats → 16 beats forwarded, the 16th with out_last=1; beats 17–20 are consumed silently; trunc_cnt=1.
- out_ready toggles 1,0,0,1 during a 4-beat packet → out_* stable while stalled; no beat lost or duplicated; payload order preserved.
- rst pulsed for 1 cycle while beat 2 of 5 is held in the output register → out_valid=0, drop_cnt=0, state=IDLE next cycle; a new packet afterwards is granted starting from rr_ptr=0.
